// File: rtl/cpu_control.sv
// Multicycle control FSM for the RV32I core: sequences fetch, decode, execute
// and memory phases and drives every datapath load, mux select and ALU/CMP op.
module cpu_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       br_en,
   input  logic [1:0] mar_lo,
   input  logic       mem_resp,
   output logic       mem_read,
   output logic       mem_write,
   output logic [3:0] mem_byte_enable,
   output logic       load_pc,
   output logic       load_ir,
   output logic       load_regfile,
   output logic       load_mar,
   output logic       load_mdr,
   output logic       load_data_out,
   output logic [1:0] pcmux_sel,
   output logic       alumux1_sel,
   output logic [2:0] alumux2_sel,
   output logic [3:0] regfilemux_sel,
   output logic       marmux_sel,
   output logic       cmpmux_sel,
   output logic [2:0] aluop,
   output logic [2:0] cmpop
);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SRA = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] CMP_BLT  = 3'b100;
   localparam logic [2:0] CMP_BLTU = 3'b110;

   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_SR   = 3'b101;

   typedef enum logic [4:0] {
      S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
      S_IMM, S_REG, S_LUI, S_AUIPC, S_BR,
      S_CALC_LD, S_LD1, S_LD2,
      S_CALC_ST, S_ST1, S_ST2,
      S_JAL, S_JALR
   } state_e;

   state_e state_q, state_d;

   logic unused_funct7;
   assign unused_funct7 = ^{funct7[6], funct7[4:0]};

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH1;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_byte_enable = 4'b1111;
      load_pc         = 1'b0;
      load_ir         = 1'b0;
      load_regfile    = 1'b0;
      load_mar        = 1'b0;
      load_mdr        = 1'b0;
      load_data_out   = 1'b0;
      pcmux_sel       = 2'd0;
      alumux1_sel     = 1'b0;
      alumux2_sel     = 3'd0;
      regfilemux_sel  = 4'd0;
      marmux_sel      = 1'b0;
      cmpmux_sel      = 1'b0;
      aluop           = ALU_ADD;
      cmpop           = 3'b000;

      // Outputs stay at their defaults while reset is asserted so no request survives it.
      if (!rst) begin
         case (state_q)
            S_FETCH1: begin
               load_mar = 1'b1;
               state_d  = S_FETCH2;
            end
            S_FETCH2: begin
               mem_read = 1'b1;
               load_mdr = 1'b1;
               if (mem_resp) state_d = S_FETCH3;
            end
            S_FETCH3: begin
               load_ir = 1'b1;
               state_d = S_DECODE;
            end
            S_DECODE: begin
               case (opcode)
                  OP_IMM:   state_d = S_IMM;
                  OP_REG:   state_d = S_REG;
                  OP_LUI:   state_d = S_LUI;
                  OP_AUIPC: state_d = S_AUIPC;
                  OP_BR:    state_d = S_BR;
                  OP_LOAD:  state_d = S_CALC_LD;
                  OP_STORE: state_d = S_CALC_ST;
                  OP_JAL:   state_d = S_JAL;
                  OP_JALR:  state_d = S_JALR;
                  default: begin
                     load_pc = 1'b1;
                     state_d = S_FETCH1;
                  end
               endcase
            end
            S_IMM: begin
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = S_FETCH1;
               case (funct3)
                  F3_SLT, F3_SLTU: begin
                     cmpmux_sel     = 1'b1;
                     cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                     regfilemux_sel = 4'd1;
                  end
                  F3_SR:   aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                  default: aluop = funct3;
               endcase
            end
            S_REG: begin
               alumux2_sel  = 3'd5;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = S_FETCH1;
               case (funct3)
                  3'b000:  aluop = funct7[5] ? ALU_SUB : ALU_ADD;
                  F3_SR:   aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                  F3_SLT, F3_SLTU: begin
                     cmpop          = (funct3 == F3_SLT) ? CMP_BLT : CMP_BLTU;
                     regfilemux_sel = 4'd1;
                  end
                  default: aluop = funct3;
               endcase
            end
            S_LUI: begin
               regfilemux_sel = 4'd2;
               load_regfile   = 1'b1;
               load_pc        = 1'b1;
               state_d        = S_FETCH1;
            end
            S_AUIPC: begin
               alumux1_sel  = 1'b1;
               alumux2_sel  = 3'd1;
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = S_FETCH1;
            end
            S_BR: begin
               alumux1_sel = 1'b1;
               alumux2_sel = 3'd2;
               cmpop       = funct3;
               pcmux_sel   = br_en ? 2'd1 : 2'd0;
               load_pc     = 1'b1;
               state_d     = S_FETCH1;
            end
            S_CALC_LD: begin
               marmux_sel = 1'b1;
               load_mar   = 1'b1;
               state_d    = S_LD1;
            end
            S_LD1: begin
               mem_read = 1'b1;
               load_mdr = 1'b1;
               if (mem_resp) state_d = S_LD2;
            end
            S_LD2: begin
               case (funct3)
                  3'b000:  regfilemux_sel = 4'd5;
                  3'b001:  regfilemux_sel = 4'd7;
                  3'b100:  regfilemux_sel = 4'd6;
                  3'b101:  regfilemux_sel = 4'd8;
                  default: regfilemux_sel = 4'd3;
               endcase
               load_regfile = 1'b1;
               load_pc      = 1'b1;
               state_d      = S_FETCH1;
            end
            S_CALC_ST: begin
               alumux2_sel   = 3'd3;
               marmux_sel    = 1'b1;
               load_mar      = 1'b1;
               load_data_out = 1'b1;
               state_d       = S_ST1;
            end
            S_ST1: begin
               mem_write = 1'b1;
               case (funct3)
                  3'b000:  mem_byte_enable = 4'b0001 << mar_lo;
                  3'b001:  mem_byte_enable = 4'b0011 << {mar_lo[1], 1'b0};
                  default: mem_byte_enable = 4'b1111;
               endcase
               if (mem_resp) state_d = S_ST2;
            end
            S_ST2: begin
               load_pc = 1'b1;
               state_d = S_FETCH1;
            end
            S_JAL: begin
               regfilemux_sel = 4'd4;
               load_regfile   = 1'b1;
               alumux1_sel    = 1'b1;
               alumux2_sel    = 3'd4;
               pcmux_sel      = 2'd1;
               load_pc        = 1'b1;
               state_d        = S_FETCH1;
            end
            S_JALR: begin
               regfilemux_sel = 4'd4;
               load_regfile   = 1'b1;
               pcmux_sel      = 2'd2;
               load_pc        = 1'b1;
               state_d        = S_FETCH1;
            end
            default: state_d = S_FETCH1;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_control.sv
// Randomized bench for cpu_control: a per-instruction model predicts the
// cycle-by-cycle control outputs and each cycle is compared against the DUT.
module tb_cpu_control;
   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       br_en;
   logic [1:0] mar_lo;
   logic       mem_resp;
   logic       mem_read, mem_write;
   logic [3:0] mem_byte_enable;
   logic       load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
   logic [1:0] pcmux_sel;
   logic       alumux1_sel;
   logic [2:0] alumux2_sel;
   logic [3:0] regfilemux_sel;
   logic       marmux_sel, cmpmux_sel;
   logic [2:0] aluop, cmpop;

   cpu_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .br_en(br_en), .mar_lo(mar_lo), .mem_resp(mem_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
      .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
      .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
      .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
      .aluop(aluop), .cmpop(cmpop)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       mrd;
      logic       mwr;
      logic [3:0] be;
      logic       lpc;
      logic       lir;
      logic       lrf;
      logic       lmar;
      logic       lmdr;
      logic       ldo;
      logic [1:0] pcm;
      logic       am1;
      logic [2:0] am2;
      logic [3:0] rfm;
      logic       mm;
      logic       cm;
      logic [2:0] aop;
      logic [2:0] cop;
   } outs_t;

   outs_t obs;
   assign obs = {mem_read, mem_write, mem_byte_enable, load_pc, load_ir, load_regfile,
                 load_mar, load_mdr, load_data_out, pcmux_sel, alumux1_sel, alumux2_sel,
                 regfilemux_sel, marmux_sel, cmpmux_sel, aluop, cmpop};

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic outs_t dflt();
      outs_t o;
      o    = '0;
      o.be = 4'b1111;
      return o;
   endfunction

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic is_known(input logic [6:0] op);
      return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_REG};
   endfunction

   // Byte lanes written by a store: one lane for sb, an aligned half for sh, all for sw.
   function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] ml);
      logic [3:0] lanes;
      lanes = 4'b0000;
      case (f3)
         3'b000: lanes[ml] = 1'b1;
         3'b001: if (ml >= 2'd2) lanes = 4'b1100; else lanes = 4'b0011;
         default: lanes = 4'b1111;
      endcase
      return lanes;
   endfunction

   function automatic logic [3:0] load_source(input logic [2:0] f3);
      case (f3)
         3'b000:  return 4'd5;
         3'b001:  return 4'd7;
         3'b100:  return 4'd6;
         3'b101:  return 4'd8;
         default: return 4'd3;
      endcase
   endfunction

   // ALU/CMP settings of an arithmetic instruction; is_reg selects the register form.
   function automatic outs_t arith(input logic is_reg, input logic [2:0] f3, input logic sub_or_arith);
      outs_t o;
      o     = dflt();
      o.lrf = 1'b1;
      o.lpc = 1'b1;
      if (is_reg) o.am2 = 3'd5;
      if (f3 == 3'b010 || f3 == 3'b011) begin
         o.cm  = !is_reg;
         o.cop = (f3 == 3'b010) ? 3'b100 : 3'b110;
         o.rfm = 4'd1;
      end else if (f3 == 3'b101) begin
         o.aop = sub_or_arith ? 3'b010 : 3'b101;
      end else if (f3 == 3'b000 && is_reg && sub_or_arith) begin
         o.aop = 3'b011;
      end else begin
         o.aop = f3;
      end
      return o;
   endfunction

   task automatic check(input outs_t exp, input string tag);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input outs_t exp, input logic resp, input string tag);
      mem_resp = resp;
      @(negedge clk);
      check(exp, tag);
      @(posedge clk);
      #1;
   endtask

   task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic br, input logic [1:0] ml, input int wf, input int wm,
                           input int abort_at);
      outs_t e;
      opcode = op; funct3 = f3; funct7 = f7; br_en = br; mar_lo = ml;
      e = dflt(); e.lmar = 1'b1;
      cyc(e, rnd(), "fetch1");
      e = dflt(); e.mrd = 1'b1; e.lmdr = 1'b1;
      for (int i = 0; i < wf; i++) cyc(e, 1'b0, "fetch2_wait");
      cyc(e, 1'b1, "fetch2_resp");
      e = dflt(); e.lir = 1'b1;
      cyc(e, rnd(), "fetch3");
      e = dflt();
      if (!is_known(op)) begin
         e.lpc = 1'b1;
         cyc(e, rnd(), "decode_nop");
         return;
      end
      cyc(e, rnd(), "decode");
      e = dflt();
      case (op)
         OP_IMM: cyc(arith(1'b0, f3, f7[5]), rnd(), "imm");
         OP_REG: cyc(arith(1'b1, f3, f7[5]), rnd(), "reg");
         OP_LUI: begin
            e.rfm = 4'd2; e.lrf = 1'b1; e.lpc = 1'b1;
            cyc(e, rnd(), "lui");
         end
         OP_AUIPC: begin
            e.am1 = 1'b1; e.am2 = 3'd1; e.lrf = 1'b1; e.lpc = 1'b1;
            cyc(e, rnd(), "auipc");
         end
         OP_BR: begin
            e.am1 = 1'b1; e.am2 = 3'd2; e.cop = f3; e.pcm = {1'b0, br}; e.lpc = 1'b1;
            cyc(e, rnd(), "branch");
         end
         OP_JAL: begin
            e.rfm = 4'd4; e.lrf = 1'b1; e.am1 = 1'b1; e.am2 = 3'd4; e.pcm = 2'd1; e.lpc = 1'b1;
            cyc(e, rnd(), "jal");
         end
         OP_JALR: begin
            e.rfm = 4'd4; e.lrf = 1'b1; e.pcm = 2'd2; e.lpc = 1'b1;
            cyc(e, rnd(), "jalr");
         end
         OP_LOAD: begin
            e.mm = 1'b1; e.lmar = 1'b1;
            cyc(e, rnd(), "calc_ld");
            e = dflt(); e.mrd = 1'b1; e.lmdr = 1'b1;
            for (int i = 0; i < wm; i++) begin
               if (i == abort_at) begin
                  rst = 1'b1;
                  cyc(dflt(), rnd(), "rst_in_ld1");
                  rst = 1'b0;
                  return;
               end
               cyc(e, 1'b0, "ld1_wait");
            end
            cyc(e, 1'b1, "ld1_resp");
            e = dflt(); e.rfm = load_source(f3); e.lrf = 1'b1; e.lpc = 1'b1;
            cyc(e, rnd(), "ld2");
         end
         default: begin
            e.am2 = 3'd3; e.mm = 1'b1; e.lmar = 1'b1; e.ldo = 1'b1;
            cyc(e, rnd(), "calc_st");
            e = dflt(); e.mwr = 1'b1; e.be = store_lanes(f3, ml);
            for (int i = 0; i < wm; i++) cyc(e, 1'b0, "st1_wait");
            cyc(e, 1'b1, "st1_resp");
            e = dflt(); e.lpc = 1'b1;
            cyc(e, rnd(), "st2");
         end
      endcase
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0] ops [9];
      logic [6:0] op;
      logic [2:0] f3;
      int         cls;
      int         wm;
      int         ab;
      ops[0] = OP_IMM;  ops[1] = OP_REG;  ops[2] = OP_LUI;
      ops[3] = OP_AUIPC; ops[4] = OP_BR;  ops[5] = OP_LOAD;
      ops[6] = OP_STORE; ops[7] = OP_JAL; ops[8] = OP_JALR;

      rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0;
      br_en = 1'b0; mar_lo = '0; mem_resp = 1'b0;
      cyc(dflt(), 1'b0, "reset_c0");
      cyc(dflt(), 1'b1, "reset_c1");
      rst = 1'b0;

      do_instr(OP_LOAD,  3'b010, 7'd0,         1'b0, 2'd0, 0, 3, -1);
      do_instr(OP_STORE, 3'b000, 7'd0,         1'b0, 2'd2, 0, 0, -1);
      do_instr(OP_STORE, 3'b001, 7'd0,         1'b0, 2'd2, 1, 2, -1);
      do_instr(OP_STORE, 3'b010, 7'd0,         1'b0, 2'd1, 0, 1, -1);
      do_instr(OP_BR,    3'b000, 7'd0,         1'b1, 2'd0, 0, 0, -1);
      do_instr(OP_BR,    3'b000, 7'd0,         1'b0, 2'd0, 0, 0, -1);
      do_instr(OP_REG,   3'b000, 7'b0100000,   1'b0, 2'd0, 0, 0, -1);
      do_instr(OP_REG,   3'b000, 7'b0000000,   1'b0, 2'd0, 0, 0, -1);
      do_instr(OP_IMM,   3'b101, 7'b0100000,   1'b0, 2'd0, 0, 0, -1);
      do_instr(7'b1111111, 3'b000, 7'd0,       1'b0, 2'd0, 0, 0, -1);
      do_instr(OP_LOAD,  3'b010, 7'd0,         1'b0, 2'd0, 0, 3, 1);
      do_instr(OP_LUI,   3'b000, 7'd0,         1'b0, 2'd0, 0, 0, -1);

      for (int n = 0; n < 250; n++) begin
         cls = $urandom_range(0, 9);
         op  = (cls == 9) ? 7'($urandom) : ops[cls];
         f3  = 3'($urandom);
         if (op == OP_LOAD) begin
            while (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) f3 = 3'($urandom);
         end else if (op == OP_STORE) begin
            f3 = 3'($urandom_range(0, 2));
         end
         wm = $urandom_range(0, 3);
         ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : -1;
         do_instr(op, f3, 7'($urandom), rnd(), 2'($urandom), $urandom_range(0, 3), wm, ab);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
